// File: rtl/inst_encoder_loader.sv
// Encodes one symbolic RV32I instruction per handshake and writes it to
// instruction memory at an auto-incrementing, word-aligned byte address.
// Each request passes through IDLE -> ENC -> WR, so a new request is
// accepted at most once every three cycles.
module inst_encoder_loader #(
    parameter int ADDR_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  base_load,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            op,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [31:0]           imm,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  err,
    output logic                  err_sticky,
    output logic [CNT_WIDTH-1:0]  wr_count
);

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_IMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD = 7'b0000011;
    localparam logic [6:0] OPC_ST   = 7'b0100011;
    localparam logic [6:0] OPC_BR   = 7'b1100011;
    localparam logic [6:0] OPC_JAL  = 7'b1101111;

    typedef enum logic [1:0] {IDLE, ENC, WR} state_t;

    state_t                state_reg, state_next;
    logic                  accept;

    logic [3:0]            op_reg;
    logic [4:0]            rd_reg, rs1_reg, rs2_reg;
    logic [31:0]           imm_reg;
    logic signed [31:0]    imm_s;

    logic [ADDR_WIDTH-1:0] ptr_reg;
    logic [ADDR_WIDTH-1:0] mem_addr_reg;
    logic [31:0]           mem_wdata_reg;
    logic                  legal_reg;
    logic                  err_sticky_reg;
    logic [CNT_WIDTH-1:0]  wr_count_reg;

    logic [31:0]           enc_word;
    logic                  enc_legal;

    assign imm_s = imm_reg;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and handshake/strobe outputs; rst masks the strobes so a
    // request caught by reset mid-flight never writes or flags an error
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        accept     = 1'b0;
        mem_we     = 1'b0;
        err        = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = !base_load && !rst;
                accept   = in_valid && in_ready;
                if (accept) begin
                    state_next = ENC;
                end
            end
            ENC: begin
                state_next = WR;
            end
            WR: begin
                mem_we     = legal_reg && !rst;
                err        = !legal_reg && !rst;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // RV32I encoding and immediate range check on the full signed 32-bit imm
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b0;
        case (op_reg)
            4'd0: begin
                enc_word  = {7'b0000000, rs2_reg, rs1_reg, 3'b000, rd_reg, OPC_R};
                enc_legal = 1'b1;
            end
            4'd1: begin
                enc_word  = {7'b0100000, rs2_reg, rs1_reg, 3'b000, rd_reg, OPC_R};
                enc_legal = 1'b1;
            end
            4'd2: begin
                enc_word  = {7'b0000000, rs2_reg, rs1_reg, 3'b100, rd_reg, OPC_R};
                enc_legal = 1'b1;
            end
            4'd3: begin
                enc_word  = {7'b0000000, rs2_reg, rs1_reg, 3'b110, rd_reg, OPC_R};
                enc_legal = 1'b1;
            end
            4'd4: begin
                enc_word  = {7'b0000000, rs2_reg, rs1_reg, 3'b111, rd_reg, OPC_R};
                enc_legal = 1'b1;
            end
            4'd5: begin
                enc_word  = {7'b0000000, rs2_reg, rs1_reg, 3'b001, rd_reg, OPC_R};
                enc_legal = 1'b1;
            end
            4'd6: begin
                enc_word  = {7'b0000000, rs2_reg, rs1_reg, 3'b101, rd_reg, OPC_R};
                enc_legal = 1'b1;
            end
            4'd7, 4'd8: begin
                enc_word  = {imm_reg[12], imm_reg[10:5], rs2_reg, rs1_reg,
                             (op_reg == 4'd7) ? 3'b000 : 3'b100,
                             imm_reg[4:1], imm_reg[11], OPC_BR};
                enc_legal = (imm_s >= -4096) && (imm_s <= 4094) && !imm_reg[0];
            end
            4'd9: begin
                enc_word  = {imm_reg[20], imm_reg[10:1], imm_reg[11], imm_reg[19:12],
                             rd_reg, OPC_JAL};
                enc_legal = (imm_s >= -1048576) && (imm_s <= 1048574) && !imm_reg[0];
            end
            4'd10: begin
                enc_word  = {imm_reg[11:0], rs1_reg, 3'b000, rd_reg, OPC_IMM};
                enc_legal = (imm_s >= -2048) && (imm_s <= 2047);
            end
            4'd11: begin
                enc_word  = {imm_reg[11:0], rs1_reg, 3'b010, rd_reg, OPC_LOAD};
                enc_legal = (imm_s >= -2048) && (imm_s <= 2047);
            end
            4'd12: begin
                enc_word  = {imm_reg[11:5], rs2_reg, rs1_reg, 3'b010, imm_reg[4:0], OPC_ST};
                enc_legal = (imm_s >= -2048) && (imm_s <= 2047);
            end
            default: begin
                enc_word  = '0;
                enc_legal = 1'b0;
            end
        endcase
    end

    // Field capture, encode latch, write pointer, counters and sticky error
    always_ff @(posedge clk) begin
        if (rst) begin
            op_reg         <= '0;
            rd_reg         <= '0;
            rs1_reg        <= '0;
            rs2_reg        <= '0;
            imm_reg        <= '0;
            ptr_reg        <= '0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            legal_reg      <= 1'b0;
            err_sticky_reg <= 1'b0;
            wr_count_reg   <= '0;
        end else begin
            if (state_reg == IDLE && base_load) begin
                ptr_reg <= base_addr & ~ADDR_WIDTH'(3);
            end
            if (accept) begin
                op_reg  <= op;
                rd_reg  <= rd;
                rs1_reg <= rs1;
                rs2_reg <= rs2;
                imm_reg <= imm;
            end
            if (state_reg == ENC) begin
                legal_reg <= enc_legal;
                // Address/data only move for a real write so they hold otherwise
                if (enc_legal) begin
                    mem_addr_reg  <= ptr_reg;
                    mem_wdata_reg <= enc_word;
                end
            end
            if (state_reg == WR) begin
                if (legal_reg) begin
                    ptr_reg      <= ptr_reg + ADDR_WIDTH'(4);
                    wr_count_reg <= wr_count_reg + CNT_WIDTH'(1);
                end else begin
                    err_sticky_reg <= 1'b1;
                end
            end
        end
    end

    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign err_sticky = err_sticky_reg;
    assign wr_count   = wr_count_reg;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Directed bench for inst_encoder_loader: table of instructions with
// hand-encoded words and addresses, plus sequences for reset-in-flight,
// base_load priority and narrow-address wrap.
module tb_inst_encoder_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        base_load = 1'b0;
    logic [31:0] base_addr = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = '0;
    logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] imm = '0;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        err;
    logic        err_sticky;
    logic [15:0] wr_count;

    logic        base_load8 = 1'b0;
    logic [7:0]  base_addr8 = '0;
    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic        mem_we8;
    logic [7:0]  mem_addr8;
    logic [31:0] mem_wdata8;
    logic        err8;
    logic        err_sticky8;
    logic [15:0] wr_count8;

    int checks = 0;
    int errors = 0;
    int exp_count = 0;
    logic exp_sticky = 1'b0;

    always #5 clk = ~clk;

    inst_encoder_loader #(.ADDR_WIDTH(32), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .base_load(base_load), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .rd(rd), .rs1(rs1),
        .rs2(rs2), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .err(err), .err_sticky(err_sticky), .wr_count(wr_count)
    );

    inst_encoder_loader #(.ADDR_WIDTH(8), .CNT_WIDTH(16)) dut8 (
        .clk(clk), .rst(rst), .base_load(base_load8), .base_addr(base_addr8),
        .in_valid(in_valid8), .in_ready(in_ready8), .op(op), .rd(rd), .rs1(rs1),
        .rs2(rs2), .imm(imm), .mem_we(mem_we8), .mem_addr(mem_addr8),
        .mem_wdata(mem_wdata8), .err(err8), .err_sticky(err_sticky8), .wr_count(wr_count8)
    );

    typedef struct {
        logic        pre_rst;
        logic        pre_base;
        logic [31:0] base;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic        legal;
        logic [31:0] word;
        logic [31:0] addr;
    } vec_t;

    localparam int NVEC = 24;
    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        base_load = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
        chk("rst_wr_count", {16'd0, wr_count}, 32'd0);
        rst = 1'b0;
        exp_count = 0;
        exp_sticky = 1'b0;
    endtask

    task automatic do_txn(input int idx, input vec_t v);
        int n;
        logic        we_seen;
        logic [31:0] addr_seen, data_seen;
        if (v.pre_rst) do_reset();
        if (v.pre_base) begin
            @(negedge clk);
            base_load = 1'b1;
            base_addr = v.base;
            @(negedge clk);
            base_load = 1'b0;
            #1;
        end
        n = 0;
        while (!in_ready && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk($sformatf("v%0d_ready_wait", idx), {31'd0, in_ready}, 32'd1);
        op = v.op; rd = v.rd; rs1 = v.rs1; rs2 = v.rs2; imm = v.imm;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk($sformatf("v%0d_enc_ready", idx), {31'd0, in_ready}, 32'd0);
        chk($sformatf("v%0d_enc_we", idx), {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        #1;
        we_seen = mem_we;
        addr_seen = mem_addr;
        data_seen = mem_wdata;
        chk($sformatf("v%0d_wr_ready", idx), {31'd0, in_ready}, 32'd0);
        chk($sformatf("v%0d_we", idx), {31'd0, mem_we}, {31'd0, v.legal});
        chk($sformatf("v%0d_err", idx), {31'd0, err}, {31'd0, !v.legal});
        if (v.legal) begin
            chk($sformatf("v%0d_addr", idx), mem_addr, v.addr);
            chk($sformatf("v%0d_wdata", idx), mem_wdata, v.word);
            exp_count++;
        end else begin
            exp_sticky = 1'b1;
        end
        @(negedge clk);
        #1;
        chk($sformatf("v%0d_idle_we", idx), {31'd0, mem_we}, 32'd0);
        chk($sformatf("v%0d_count", idx), {16'd0, wr_count}, exp_count);
        chk($sformatf("v%0d_sticky", idx), {31'd0, err_sticky}, {31'd0, exp_sticky});
        $display("txn %0d: op=%0d imm=%h we=%0b addr=%h wdata=%h count=%0d sticky=%0b",
                 idx, v.op, v.imm, we_seen, addr_seen, data_seen, wr_count, err_sticky);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        //         rst   base  base_addr     op     rd     rs1    rs2    imm            legal word           addr
        vecs[0]  = '{1'b1, 1'b0, 32'h0,   4'd10, 5'd1, 5'd0, 5'd0, 32'd5,        1'b1, 32'h00500093, 32'h000};
        vecs[1]  = '{1'b1, 1'b0, 32'h0,   4'd0,  5'd3, 5'd1, 5'd2, 32'd0,        1'b1, 32'h002081B3, 32'h000};
        vecs[2]  = '{1'b0, 1'b0, 32'h0,   4'd1,  5'd3, 5'd1, 5'd2, 32'd0,        1'b1, 32'h402081B3, 32'h004};
        vecs[3]  = '{1'b0, 1'b0, 32'h0,   4'd12, 5'd9, 5'd1, 5'd2, 32'd8,        1'b1, 32'h0020A423, 32'h008};
        vecs[4]  = '{1'b0, 1'b0, 32'h0,   4'd11, 5'd5, 5'd1, 5'd0, 32'd12,       1'b1, 32'h00C0A283, 32'h00C};
        vecs[5]  = '{1'b0, 1'b1, 32'h103, 4'd7,  5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b1, 32'hFE208EE3, 32'h100};
        vecs[6]  = '{1'b0, 1'b0, 32'h0,   4'd9,  5'd1, 5'd7, 5'd7, 32'd8,        1'b1, 32'h008000EF, 32'h104};
        vecs[7]  = '{1'b0, 1'b0, 32'h0,   4'd10, 5'd1, 5'd0, 5'd0, 32'd2048,     1'b0, 32'h0,        32'h0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0,   4'd7,  5'd0, 5'd1, 5'd2, 32'd3,        1'b0, 32'h0,        32'h0};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,   4'd14, 5'd1, 5'd1, 5'd1, 32'd0,        1'b0, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 1'b0, 32'h0,   4'd10, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 1'b1, 32'h80000093, 32'h108};
        vecs[11] = '{1'b0, 1'b0, 32'h0,   4'd2,  5'd4, 5'd5, 5'd6, 32'd0,        1'b1, 32'h0062C233, 32'h10C};
        vecs[12] = '{1'b0, 1'b0, 32'h0,   4'd3,  5'd1, 5'd2, 5'd3, 32'd0,        1'b1, 32'h003160B3, 32'h110};
        vecs[13] = '{1'b0, 1'b0, 32'h0,   4'd4,  5'd1, 5'd2, 5'd3, 32'hDEAD,     1'b1, 32'h003170B3, 32'h114};
        vecs[14] = '{1'b0, 1'b0, 32'h0,   4'd5,  5'd7, 5'd7, 5'd7, 32'd0,        1'b1, 32'h007393B3, 32'h118};
        vecs[15] = '{1'b0, 1'b0, 32'h0,   4'd6,  5'd7, 5'd7, 5'd7, 32'd0,        1'b1, 32'h0073D3B3, 32'h11C};
        vecs[16] = '{1'b0, 1'b0, 32'h0,   4'd8,  5'd0, 5'd1, 5'd2, 32'd4094,     1'b1, 32'h7E20CFE3, 32'h120};
        vecs[17] = '{1'b0, 1'b0, 32'h0,   4'd8,  5'd0, 5'd1, 5'd2, 32'd4096,     1'b0, 32'h0,        32'h0};
        vecs[18] = '{1'b0, 1'b0, 32'h0,   4'd9,  5'd0, 5'd0, 5'd0, 32'hFFF00000, 1'b1, 32'h8000006F, 32'h124};
        vecs[19] = '{1'b0, 1'b0, 32'h0,   4'd9,  5'd1, 5'd0, 5'd0, 32'h00100000, 1'b0, 32'h0,        32'h0};
        vecs[20] = '{1'b0, 1'b0, 32'h0,   4'd10, 5'd1, 5'd0, 5'd0, 32'h00001000, 1'b0, 32'h0,        32'h0};
        vecs[21] = '{1'b0, 1'b0, 32'h0,   4'd12, 5'd0, 5'd1, 5'd2, 32'hFFFFF800, 1'b1, 32'h8020A023, 32'h128};
        vecs[22] = '{1'b0, 1'b0, 32'h0,   4'd13, 5'd1, 5'd1, 5'd1, 32'd0,        1'b0, 32'h0,        32'h0};
        vecs[23] = '{1'b0, 1'b0, 32'h0,   4'd15, 5'd1, 5'd1, 5'd1, 32'd0,        1'b0, 32'h0,        32'h0};

        for (int i = 0; i < NVEC; i++) begin
            do_txn(i, vecs[i]);
        end

        // Reset asserted while a request sits in ENC: no write may follow
        do_reset();
        @(negedge clk);
        op = 4'd10; rd = 5'd1; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd5;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_enc_we", {31'd0, mem_we}, 32'd0);
        chk("rst_enc_err", {31'd0, err}, 32'd0);
        chk("rst_enc_ready", {31'd0, in_ready}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_enc_we_after", {31'd0, mem_we}, 32'd0);
        chk("rst_enc_addr", mem_addr, 32'd0);
        chk("rst_enc_wdata", mem_wdata, 32'd0);
        chk("rst_enc_count", {16'd0, wr_count}, 32'd0);
        chk("rst_enc_ready_after", {31'd0, in_ready}, 32'd1);
        $display("seq rst_in_enc: we=%0b count=%0d", mem_we, wr_count);

        // base_load and in_valid together: base_load wins, fields taken next cycle
        base_load = 1'b1;
        base_addr = 32'h40;
        op = 4'd10; rd = 5'd1; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd5;
        in_valid = 1'b1;
        #1;
        chk("prio_ready_low", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        base_load = 1'b0;
        #1;
        chk("prio_still_idle", {31'd0, in_ready}, 32'd1);
        chk("prio_no_we", {31'd0, mem_we}, 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("prio_enc", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        #1;
        chk("prio_we", {31'd0, mem_we}, 32'd1);
        chk("prio_addr", mem_addr, 32'h40);
        chk("prio_wdata", mem_wdata, 32'h00500093);
        $display("seq base_prio: we=%0b addr=%h wdata=%h", mem_we, mem_addr, mem_wdata);

        // 8-bit address instance: pointer 0xFC wraps to 0x00
        @(negedge clk);
        base_load8 = 1'b1;
        base_addr8 = 8'hFE;
        @(negedge clk);
        base_load8 = 1'b0;
        for (int k = 0; k < 2; k++) begin
            op = 4'd10; rd = 5'd2; rs1 = 5'd0; rs2 = 5'd0; imm = 32'd1;
            in_valid8 = 1'b1;
            @(negedge clk);
            in_valid8 = 1'b0;
            @(negedge clk);
            #1;
            chk($sformatf("wrap%0d_we", k), {31'd0, mem_we8}, 32'd1);
            chk($sformatf("wrap%0d_addr", k), {24'd0, mem_addr8}, (k == 0) ? 32'hFC : 32'h00);
            chk($sformatf("wrap%0d_wdata", k), mem_wdata8, 32'h00100113);
            $display("seq wrap8 %0d: we=%0b addr=%h", k, mem_we8, mem_addr8);
            @(negedge clk);
        end
        #1;
        chk("wrap_count", {16'd0, wr_count8}, 32'd2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
